// File: rtl/div_const_arb_pkg.sv
// Shared constants for the constant-divisor arbiter: operand widths, the divisor
// itself, and a clog2 helper for sizing requester tags.
package div_const_arb_pkg;

    localparam int XW      = 16;
    localparam int DIVISOR = 23;
    localparam int QW      = 12;
    localparam int RW      = 5;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << w) < n) w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/div_const_arb_if.sv
// Requester/response bundle. A request transfers on req_valid[i] && req_ready[i];
// a response transfers on rsp_valid && rsp_ready, and rsp_* hold while stalled.
interface div_const_arb_if
    import div_const_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*XW-1:0] req_x;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [QW-1:0]       rsp_q;
    logic [RW-1:0]       rsp_r;
    logic [15:0]         done_cnt;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, done_cnt
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, done_cnt
    );
endinterface

// File: rtl/div_const_arb_core.sv
// Combinational X -> {Q, R} for the package's constant divisor.
module div_const_core
    import div_const_arb_pkg::*;
(
    input  logic [XW-1:0] i_x,
    output logic [QW-1:0] o_q,
    output logic [RW-1:0] o_r
);
    localparam logic [XW-1:0] C_DIV = XW'(DIVISOR);

    // QW holds the largest quotient and RW holds DIVISOR-1, so the casts only drop zero bits
    assign o_q = QW'(i_x / C_DIV);
    assign o_r = RW'(i_x - XW'(o_q) * C_DIV);
endmodule

// File: rtl/div_const_arb.sv
// Round-robin sharing of one constant divider among N_REQ requesters, with an
// input register (S1) and an output register (S2) around the divide core.
module div_const_arb
    import div_const_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW  = clog2(N_REQ)
)(
    input  logic               clk,
    input  logic               rst_n,
    div_const_arb_if.slave     bus,
    output logic [IDW-1:0]     o_rr_ptr
);
    logic              r_v1;
    logic [XW-1:0]     r_x1;
    logic [IDW-1:0]    r_id1;
    logic              r_v2;
    logic [QW-1:0]     r_q2;
    logic [RW-1:0]     r_r2;
    logic [IDW-1:0]    r_id2;
    logic [IDW-1:0]    r_ptr;
    logic [15:0]       r_done_cnt;

    logic              w_adv1;
    logic              w_adv2;
    logic              w_any;
    logic [IDW-1:0]    w_idx;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_ptr_next;
    logic [N_REQ-1:0]  w_grant;
    logic [XW-1:0]     w_x_sel;
    logic [QW-1:0]     w_q;
    logic [RW-1:0]     w_r;

    assign w_adv2 = !r_v2 || bus.rsp_ready;
    assign w_adv1 = !r_v1 || w_adv2;

    // Search upward from r_ptr with explicit wrap so non-power-of-2 N_REQ works
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N_REQ)) w_sum = w_sum - (IDW+1)'(N_REQ);
            if (!w_any && bus.req_valid[w_sum[IDW-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_adv1 && w_any) w_grant[w_idx] = 1'b1;
    end

    always_comb begin
        w_x_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDW'(k) == w_idx) w_x_sel = bus.req_x[k*XW +: XW];
        end
    end

    assign w_ptr_next = (w_idx == IDW'(N_REQ-1)) ? '0 : w_idx + IDW'(1);

    div_const_core u_core (
        .i_x (r_x1),
        .o_q (w_q),
        .o_r (w_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_x1       <= '0;
            r_id1      <= '0;
            r_v2       <= 1'b0;
            r_q2       <= '0;
            r_r2       <= '0;
            r_id2      <= '0;
            r_ptr      <= '0;
            r_done_cnt <= '0;
        end else begin
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_q2  <= w_q;
                    r_r2  <= w_r;
                    r_id2 <= r_id1;
                end
            end
            if (w_adv1) begin
                r_v1 <= w_any;
                if (w_any) begin
                    r_x1  <= w_x_sel;
                    r_id1 <= w_idx;
                    r_ptr <= w_ptr_next;
                end
            end
            if (r_v2 && bus.rsp_ready) r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_v2;
    assign bus.rsp_id    = r_id2;
    assign bus.rsp_q     = r_q2;
    assign bus.rsp_r     = r_r2;
    assign bus.done_cnt  = r_done_cnt;
    assign o_rr_ptr      = r_ptr;
endmodule

// File: tb/tb_div_const_arb.sv
// Directed bench for div_const_arb: hand-computed quotients/remainders, grant
// order, backpressure hold and mid-traffic reset.
module tb_div_const_arb;
    localparam int N_REQ = 4;
    localparam int XW    = 16;
    localparam int QW    = 12;
    localparam int RW    = 5;
    localparam int IDW   = 2;
    localparam int RSPW  = IDW + QW + RW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IDW-1:0]  rr_ptr;
    logic [RSPW-1:0] exp_q[$];
    logic [RSPW-1:0] got;
    logic [RSPW-1:0] expv;
    int              n_checks = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    div_const_arb_if #(.N_REQ(N_REQ), .IDW(IDW)) bus ();

    div_const_arb #(.N_REQ(N_REQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .o_rr_ptr (rr_ptr)
    );

    function automatic logic [RSPW-1:0] mk(input int id, input int q, input int r);
        return {IDW'(id), QW'(q), RW'(r)};
    endfunction

    task automatic set_x(input int i, input logic [XW-1:0] x);
        bus.req_x[i*XW +: XW] = x;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0b exp 0", bus.rsp_valid); end
        got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
        n_checks++; if (got !== '0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", got); end
        n_checks++; if (bus.done_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_done_cnt got %0d exp 0", bus.done_cnt); end
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
        n_checks++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr got %0d exp 0", rr_ptr); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        set_x(2, 16'hFFFF);
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b exp 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %0b exp 0", bus.rsp_valid); end
        @(negedge clk);
        got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
        expv = mk(2, 2849, 8);
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b exp 1", bus.rsp_valid); end
        n_checks++; if (got !== expv) begin n_fail++; $display("FAIL single_rsp got %h exp %h", got, expv); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop got %0b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.done_cnt !== 16'd1) begin n_fail++; $display("FAIL single_done_cnt got %0d exp 1", bus.done_cnt); end
    endtask

    task automatic test_boundary();
        logic [XW-1:0]   xs[5];
        logic [RSPW-1:0] ex[5];
        xs = '{16'd0, 16'd22, 16'd23, 16'd1000, 16'd46};
        ex = '{mk(0, 0, 0), mk(0, 0, 22), mk(0, 1, 0), mk(0, 43, 11), mk(0, 2, 0)};
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL boundary_valid[%0d] got %0b exp 1", c-2, bus.rsp_valid); end
                n_checks++; if (got !== expv) begin n_fail++; $display("FAIL boundary_rsp[%0d] got %h exp %h", c-2, got, expv); end
            end
            if (c < 5) begin
                bus.req_valid = 4'b0001;
                set_x(0, xs[c]);
                exp_q.push_back(ex[c]);
                #1;
                n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL boundary_grant[%0d] got %b exp 0001", c, bus.req_ready); end
            end else begin
                bus.req_valid = '0;
            end
        end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL boundary_tail_valid got %0b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.done_cnt !== 16'd6) begin n_fail++; $display("FAIL boundary_done_cnt got %0d exp 6", bus.done_cnt); end
    endtask

    task automatic test_all_four();
        logic [RSPW-1:0] ex[4];
        logic [3:0]      onehot;
        apply_reset();
        set_x(0, 16'd7);
        set_x(1, 16'd107);
        set_x(2, 16'd207);
        set_x(3, 16'd307);
        ex = '{mk(0, 0, 7), mk(1, 4, 15), mk(2, 9, 0), mk(3, 13, 8)};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %0b exp 1", c-2, bus.rsp_valid); end
                n_checks++; if (got !== expv) begin n_fail++; $display("FAIL rr_rsp[%0d] got %h exp %h", c-2, got, expv); end
            end
            if (c < 8) begin
                bus.req_valid = 4'b1111;
                onehot = 4'b0001 << (c % 4);
                exp_q.push_back(ex[c % 4]);
                #1;
                n_checks++; if (bus.req_ready !== onehot) begin n_fail++; $display("FAIL rr_grant[%0d] got %b exp %b", c, bus.req_ready, onehot); end
            end else begin
                bus.req_valid = '0;
            end
        end
        @(negedge clk);
        n_checks++; if (bus.done_cnt !== 16'd8) begin n_fail++; $display("FAIL rr_done_cnt got %0d exp 8", bus.done_cnt); end
    endtask

    task automatic test_pair();
        logic [3:0]      vtab[7];
        logic [3:0]      rtab[7];
        vtab = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
        rtab = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        set_x(1, 16'd50);
        set_x(3, 16'd100);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++; if (rr_ptr !== 2'd2) begin n_fail++; $display("FAIL pair_ptr got %0d exp 2", rr_ptr); end
            end
            if (c >= 2 && c <= 5) begin
                got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                n_checks++; if (got !== expv || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL pair_rsp[%0d] got %h valid %0b exp %h", c-2, got, bus.rsp_valid, expv); end
            end
            bus.req_valid = vtab[c];
            if (rtab[c] == 4'b0010) exp_q.push_back(mk(1, 2, 4));
            if (rtab[c] == 4'b1000) exp_q.push_back(mk(3, 4, 8));
            #1;
            n_checks++; if (bus.req_ready !== rtab[c]) begin n_fail++; $display("FAIL pair_grant[%0d] got %b exp %b", c, bus.req_ready, rtab[c]); end
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL pair_leftover got %0d exp 0", exp_q.size()); end
        n_checks++; if (bus.done_cnt !== 16'd12) begin n_fail++; $display("FAIL pair_done_cnt got %0d exp 12", bus.done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [RSPW-1:0] first;
        apply_reset();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        set_x(0, 16'd100);
        exp_q.push_back(mk(0, 4, 8));
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant0 got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        set_x(0, 16'd200);
        exp_q.push_back(mk(0, 8, 16));
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant1 got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        set_x(0, 16'd300);
        #1;
        first = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
        n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_full got %b exp 0000", bus.req_ready); end
        n_checks++; if (first !== mk(0, 4, 8) || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first got %h valid %0b exp %h", first, bus.rsp_valid, mk(0, 4, 8)); end
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
            n_checks++; if (got !== first || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got %h valid %0b exp %h", h, got, bus.rsp_valid, first); end
            n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_ready[%0d] got %b exp 0000", h, bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        exp_q.push_back(mk(0, 13, 1));
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_grant got %b exp 0001", bus.req_ready); end
        for (int d = 0; d < 3; d++) begin
            if (d > 0) @(negedge clk);
            if (d == 1) bus.req_valid = '0;
            got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            n_checks++; if (got !== expv || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain[%0d] got %h valid %0b exp %h", d, got, bus.rsp_valid, expv); end
        end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_tail_valid got %0b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.done_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_done_cnt got %0d exp 3", bus.done_cnt); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_x(1, 16'd46);
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_x(2, 16'd23);
        @(negedge clk);
        bus.req_valid = '0;
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_inflight got %0b exp 1", bus.rsp_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_drop got %0b exp 0", bus.rsp_valid); end
        n_checks++; if (rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rmid_ptr got %0d exp 0", rr_ptr); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0110;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_first_grant got %b exp 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = '0;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale got %0b exp 0", bus.rsp_valid); end
        @(negedge clk);
        got = {bus.rsp_id, bus.rsp_q, bus.rsp_r};
        n_checks++; if (got !== mk(1, 2, 0) || bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_rsp got %h valid %0b exp %h", got, bus.rsp_valid, mk(1, 2, 0)); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_tail_valid got %0b exp 0", bus.rsp_valid); end
        n_checks++; if (bus.done_cnt !== 16'd1) begin n_fail++; $display("FAIL rmid_done_cnt got %0d exp 1", bus.done_cnt); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_boundary();
        test_all_four();
        test_pair();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
